// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch_unit (master) and memory (slave).
// Request is level-held until the single-cycle ack strobe.
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: FETCH -> WAIT -> EXEC instruction fetch, 3 cycles minimum per instruction; stall holds EXEC.
// Optional WAIT-state timeout selected by macro FETCH_TIMEOUT_EN (default build: WAIT is unbounded).
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [7:0]  TIMEOUT_CYC = 8'd255
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master imem,
  input  logic [1:0]   branch,
  input  logic         eq,
  input  logic [9:0]   imm,
  input  logic [15:0]  jalr_target,
  input  logic         stall,
  output logic [15:0]  ir,
  output logic [15:0]  pc,
  output logic         ir_valid,
  output logic         ill_op,
  output logic         bus_err
);
  typedef enum logic [1:0] {FETCH, WAIT, EXEC} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic        ill_op_q, ill_op_d;
  logic [15:0] seq_pc, next_pc;
  logic        fetch_req;
  logic        unused_in;
`ifdef FETCH_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;
`endif

  always_comb begin
    seq_pc  = pc_q + 16'd1;
    next_pc = seq_pc;
    case (branch)
      2'b01:   next_pc = jalr_target;
      2'b10:   if (eq) next_pc = seq_pc + {{9{imm[6]}}, imm[6:0]};
      default: next_pc = seq_pc;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    ill_op_d   = ill_op_q;
    fetch_req  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d      = cnt_q;
    bus_err_d  = bus_err_q;
`endif
    case (state_q)
      FETCH: begin
        fetch_req = 1'b1;
        state_d   = WAIT;
`ifdef FETCH_TIMEOUT_EN
        cnt_d     = 8'd0;
`endif
      end
      WAIT: begin
        fetch_req = 1'b1;
        if (imem.imem_ack) begin
          ir_d       = imem.imem_rdata;
          ir_valid_d = 1'b1;
          state_d    = EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        // Give up on the cycle the ack-less count reaches the limit; a NOP is executed instead.
        else if (cnt_q + 8'd1 == TIMEOUT_CYC) begin
          cnt_d      = cnt_q + 8'd1;
          ir_d       = 16'h0000;
          ir_valid_d = 1'b1;
          bus_err_d  = 1'b1;
          state_d    = EXEC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      EXEC: begin
        if (!stall) begin
          pc_d       = next_pc;
          ir_valid_d = 1'b0;
          state_d    = FETCH;
          if (branch == 2'b11) ill_op_d = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      ir_valid_q <= 1'b0;
      ill_op_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      ill_op_q   <= ill_op_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err   = bus_err_q;
  assign unused_in = ^imm[9:7];
`else
  assign bus_err   = 1'b0;
  assign unused_in = ^{imm[9:7], TIMEOUT_CYC};
`endif

  // Request is masked while rst is high so nothing is issued during reset.
  assign imem.imem_req  = fetch_req & ~rst;
  assign imem.imem_addr = pc_q;
  assign ir             = ir_q;
  assign pc             = pc_q;
  assign ir_valid       = ir_valid_q;
  assign ill_op         = ill_op_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model returns addr ^ 16'hA5A5 after a programmable delay.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  branch = 2'b00;
  logic        eq = 1'b0;
  logic [9:0]  imm = 10'd0;
  logic [15:0] jalr_target = 16'h0000;
  logic        stall = 1'b0;
  logic [15:0] ir, pc;
  logic        ir_valid, ill_op, bus_err;

  logic        ack_en = 1'b1;
  logic        ack_force = 1'b0;
  int          ack_dly = 0;
  logic [15:0] req_cnt = 16'd0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic        prev_req = 1'b0;
  logic [15:0] fa[$];
  int          fc[$];
  logic [15:0] fir[$];

  fetch_unit_if imem ();

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem(imem),
    .branch(branch), .eq(eq), .imm(imm), .jalr_target(jalr_target), .stall(stall),
    .ir(ir), .pc(pc), .ir_valid(ir_valid), .ill_op(ill_op), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    req_cnt <= imem.imem_req ? req_cnt + 16'd1 : 16'd0;
  end

  assign imem.imem_ack   = ack_force | (ack_en & imem.imem_req & (req_cnt >= 16'(ack_dly + 1)));
  assign imem.imem_rdata = imem.imem_addr ^ 16'hA5A5;

  // Log each FETCH cycle (rising request) with its address, cycle and the ir seen then.
  always @(negedge clk) begin
    if (imem.imem_req && !prev_req) begin
      fa.push_back(imem.imem_addr);
      fc.push_back(cyc);
      fir.push_back(ir);
    end
    prev_req <= imem.imem_req;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic next_fetch(input int lim, output logic [15:0] a, output int c, output logic [15:0] irv);
    int n;
    n = 0;
    while (fa.size() == 0 && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (fa.size() == 0) begin
      chk("fetch_seen", 32'd0, 32'd1);
      a = 16'hDEAD; c = 0; irv = 16'hDEAD;
    end else begin
      a = fa.pop_front(); c = fc.pop_front(); irv = fir.pop_front();
    end
  endtask

  task automatic do_instr(input logic [1:0] br, input logic e, input logic [9:0] im,
                          input logic [15:0] jt, output logic [15:0] a, output logic [15:0] irv);
    int c;
    tick();
    branch = br; eq = e; imm = im; jalr_target = jt;
    next_fetch(20, a, c, irv);
  endtask

  initial begin
    logic [15:0] a0, a1, a2, irv;
    int c0, c1, c2, n;

    tick(); tick();
    chk("rst_req", imem.imem_req, 1'b0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_vld", ir_valid, 1'b0);
    chk("rst_ill", ill_op, 1'b0);
    chk("rst_berr", bus_err, 1'b0);
    rst = 1'b0;
    #1;
    chk("rel_req", imem.imem_req, 1'b1);

    next_fetch(20, a0, c0, irv);
    next_fetch(20, a1, c1, irv);
    chk("seq_ir0", irv, 16'hA5A5);
    next_fetch(20, a2, c2, irv);
    chk("seq_ir1", irv, 16'hA5A4);
    chk("seq_a0", a0, 16'h0000);
    chk("seq_a1", a1, 16'h0001);
    chk("seq_a2", a2, 16'h0002);
    chk("seq_gap1", c1 - c0, 32'd3);
    chk("seq_gap2", c2 - c1, 32'd3);
    chk("seq_ill", ill_op, 1'b0);

    do_instr(2'b01, 1'b0, 10'd0, 16'h0010, a0, irv);
    chk("jalr_10", a0, 16'h0010);
    do_instr(2'b10, 1'b1, 10'h37E, 16'h0000, a0, irv);
    chk("beq_taken", a0, 16'h000F);
    chk("beq_ir", irv, 16'hA5B5);
    do_instr(2'b01, 1'b0, 10'd0, 16'h0010, a0, irv);
    do_instr(2'b10, 1'b0, 10'h07E, 16'h0000, a0, irv);
    chk("beq_not", a0, 16'h0011);
    do_instr(2'b01, 1'b0, 10'd0, 16'hFFFF, a0, irv);
    chk("jalr_ffff", a0, 16'hFFFF);
    do_instr(2'b00, 1'b0, 10'd0, 16'h0000, a0, irv);
    chk("wrap", a0, 16'h0000);
    chk("wrap_ir", irv, 16'h5A5A);

    do_instr(2'b11, 1'b0, 10'd0, 16'h0000, a0, irv);
    chk("ill_pc", a0, 16'h0001);
    chk("ill_set", ill_op, 1'b1);

    tick();
    branch = 2'b00; stall = 1'b1;
    n = 0;
    while (!ir_valid && n < 10) begin tick(); n++; end
    for (int i = 0; i < 4; i++) begin
      chk("stall_pc", pc, 16'h0001);
      chk("stall_ir", ir, 16'hA5A4);
      chk("stall_req", imem.imem_req, 1'b0);
      chk("stall_vld", ir_valid, 1'b1);
      tick();
    end
    chk("ill_sticky", ill_op, 1'b1);
    stall = 1'b0; ack_dly = 5;

    next_fetch(20, a0, c0, irv);
    chk("ws_addr0", a0, 16'h0002);
    n = 0;
    tick();
    while (!ir_valid && n < 20) begin
      chk("ws_req", imem.imem_req, 1'b1);
      chk("ws_addr", imem.imem_addr, 16'h0002);
      n++;
      tick();
    end
    chk("ws_len", n, 32'd6);
    chk("ws_ir", ir, 16'hA5A7);
    chk("ws_exec_req", imem.imem_req, 1'b0);

    ack_dly = 0; ack_en = 1'b0;
    next_fetch(20, a0, c0, irv);
    chk("mw_addr", a0, 16'h0003);
    tick();
    rst = 1'b1; ack_force = 1'b1;
    tick();
    chk("mw_pc", pc, 16'h0000);
    chk("mw_ir", ir, 16'h0000);
    chk("mw_vld", ir_valid, 1'b0);
    chk("mw_ill", ill_op, 1'b0);
    chk("mw_req", imem.imem_req, 1'b0);
    ack_force = 1'b0;
    tick();
    chk("mw_req_hold", imem.imem_req, 1'b0);
    rst = 1'b0; ack_en = 1'b1;
    #1;
    chk("mw_rel_req", imem.imem_req, 1'b1);
    next_fetch(20, a0, c0, irv);
    chk("mw_first", a0, 16'h0000);

    next_fetch(20, a0, c0, irv);
    chk("to_addr", a0, 16'h0001);
    ack_en = 1'b0;
    n = 0;
    tick();
    while (!ir_valid && n < 300) begin n++; tick(); end
`ifdef FETCH_TIMEOUT_EN
    chk("to_len", n, 32'd255);
    chk("to_berr", bus_err, 1'b1);
    chk("to_ir", ir, 16'h0000);
    chk("to_vld", ir_valid, 1'b1);
`else
    chk("no_to_len", n, 32'd300);
    chk("no_to_berr", bus_err, 1'b0);
    chk("no_to_req", imem.imem_req, 1'b1);
    ack_en = 1'b1;
    n = 0;
    while (!ir_valid && n < 10) begin tick(); n++; end
    chk("late_vld", ir_valid, 1'b1);
    chk("late_ir", ir, 16'hA5A4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have these parameters: RESET_PC, 16'h0000, pc value loaded on reset; TIMEOUT_CYC, 8'd255, wait-state limit used only when FETCH_TIMEOUT_EN is defined.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset: synchronous, active-high
- imem_req  out  1  instruction-memory read request
- imem_addr  out  16  word address of the requested instruction
- imem_rdata  in  16  instruction word, valid when imem_ack=1
- imem_ack  in  1  memory response strobe
- branch  in  2  from decoder: 00 sequential, 01 JALR, 10 BEQ, 11 illegal
- eq  in  1  ALU equality result for BEQ
- imm  in  10  decoder immediate; bits [6:0] are the BEQ offset
- jalr_target  in  16  register value for JALR target
- stall  in  1  execute stage not finished; hold current instruction
- ir  out  16  instruction register to decoder
- pc  out  16  address of the instruction in ir
- ir_valid  out  1  high while ir holds an instruction under execution
- ill_op  out  1  sticky illegal-branch-code flag
- bus_err  out  1  sticky fetch-timeout flag

Function
REQ-003 The FSM SHALL have states FETCH, WAIT and EXEC; rst forces FETCH.
REQ-004 FETCH SHALL drive imem_req=1 and imem_addr=pc for one cycle, then go to WAIT.
REQ-005 WAIT SHALL hold imem_req=1 and imem_addr=pc until imem_ack=1.
- On ack: ir<=imem_rdata, ir_valid<=1, next state EXEC.
REQ-006 An imem_ack arriving in FETCH or EXEC SHALL be ignored.
REQ-007 In EXEC with stall=1, the FSM SHALL hold pc, ir and ir_valid unchanged.
REQ-008 In EXEC with stall=0, the block SHALL load pc with next_pc, clear ir_valid and go to FETCH on the next edge.
REQ-009 next_pc SHALL be computed as follows:
- 00: pc+1
- 01: jalr_target
- 10: pc+1+sign_extend(imm[6:0]) if eq=1, else pc+1
- 11: pc+1, with ill_op set to 1
REQ-010 All pc arithmetic SHALL be modulo 2^16; 16'hFFFF+1 wraps to 16'h0000.
REQ-011 imem_req SHALL be 0 in EXEC, so the minimum instruction period is 3 cycles (FETCH, WAIT with immediate ack, EXEC).
REQ-012 ir SHALL change only on an accepted ack or on reset.

Reset
REQ-013 On a rising edge with rst=1, the block SHALL set:
- pc=RESET_PC
- ir=16'h0000 (NOP, ADD r0,r0,r0)
- ir_valid=0, imem_req=0
- ill_op=0, bus_err=0
- state=FETCH
REQ-014 rst asserted mid-WAIT SHALL abandon the outstanding request, and an ack arriving in the same cycle SHALL be discarded.
REQ-015 With rst held high, imem_req SHALL remain 0.
REQ-016 After rst is released, the first request SHALL be issued in the following cycle.

Configuration
REQ-017 Macro FETCH_TIMEOUT_EN SHALL control the WAIT-state timeout as follows.
- Defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle without ack. When the count reaches TIMEOUT_CYC, the block SHALL set ir=16'h0000, ir_valid=1, bus_err=1 (sticky until reset) and go to EXEC.
- Not defined: no counter is present, bus_err is tied 0, and WAIT may last indefinitely.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Sequential fetch: rst released, RESET_PC=0, zero-wait ack, branch=00, stall=0 -> imem_addr 0,1,2 on consecutive FETCHes, 3 cycles apart; ir matches memory.
- BEQ backward taken: pc=16'h0010, branch=10, eq=1, imm[6:0]=7'h7E (-2) -> next imem_addr=16'h000F; with eq=0 -> 16'h0011.
- JALR plus wrap: branch=01, jalr_target=16'hFFFF, then branch=00 -> addresses 16'hFFFF then 16'h0000.
- Stall and wait states: stall=1 for 4 cycles in EXEC -> pc/ir stable, no imem_req; ack delayed 5 cycles -> imem_req and imem_addr held throughout.
- Reset mid-WAIT: rst asserted while waiting, coincident ack -> ir=0, pc=RESET_PC, ir_valid=0.
- Illegal code and timeout: branch=11 -> ill_op=1, next pc=pc+1. With FETCH_TIMEOUT_EN defined and no ack for 255 cycles -> bus_err=1, ir=0.
